// File: rtl/mux_scan_n_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the scanning multiplexer family.
//   MODE_MANUAL / MODE_SCAN : encodings of the `mode` input.
//   chan_slice()            : extracts channel i (width w) from a packed flat
//                             vector. Channel i always sits at [i*w +: w]; no
//                             index reversal. Keeping this in one function
//                             keeps the bit-order rule in a single place.
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Upper bounds for the flat bus and a single channel handled by chan_slice.
  localparam int unsigned CHAN_FLAT_MAX = 512;
  localparam int unsigned CHAN_W_MAX    = 64;

  // Return channel i of width w; bits above w are zero.
  function automatic logic [CHAN_W_MAX-1:0] chan_slice(
    input logic [CHAN_FLAT_MAX-1:0] flat,
    input int unsigned              i,
    input int unsigned              w
  );
    logic [CHAN_W_MAX-1:0] keep;
    logic [CHAN_W_MAX-1:0] slice;
    // Shifting the mask by w yields all-zero when w == CHAN_W_MAX, so the
    // inverted mask then keeps every bit.
    keep  = ~({CHAN_W_MAX{1'b1}} << w);
    slice = CHAN_W_MAX'(flat >> (i * w));
    return slice & keep;
  endfunction

endpackage

// File: rtl/mux_scan_n_rr_find_next.sv
// -----------------------------------------------------------------------------
// rr_find_next
// Combinational wrap-around priority search: starting at i_start, find the
// first set bit of i_mask, wrapping modulo N.
// Ports:
//   i_mask  [N]     candidate mask
//   i_start [SEL_W] position to start searching from (expected < N)
//   o_found         at least one mask bit is set
//   o_idx   [SEL_W] index of the first set bit at or after i_start (mod N)
// -----------------------------------------------------------------------------
module rr_find_next #(
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     i_mask,
  input  logic [SEL_W-1:0] i_start,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  // Doubling the mask turns the wrapped search into a linear one: after the
  // shift, bit j of w_rot corresponds to channel (i_start + j) mod N.
  assign w_dbl = {i_mask, i_mask};
  assign w_rot = N'(w_dbl >> i_start);

  // Lowest set bit of the rotated mask, mapped back to a channel index.
  always_comb begin
    logic [SEL_W:0] w_sum;
    o_found = 1'b0;
    o_idx   = {SEL_W{1'b0}};
    w_sum   = {(SEL_W+1){1'b0}};
    for (int unsigned j = 0; j < N; j++) begin
      if (!o_found && w_rot[j]) begin
        o_found = 1'b1;
        w_sum   = {1'b0, i_start} + (SEL_W+1)'(j);
        if (w_sum >= (SEL_W+1)'(N)) begin
          o_idx = SEL_W'(w_sum - (SEL_W+1)'(N));
        end else begin
          o_idx = SEL_W'(w_sum);
        end
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// -----------------------------------------------------------------------------
// mux_scan_n
// Registered N-channel, W-bit multiplexer with a valid/ready output handshake.
// Manual mode picks the channel from `sel`; scan mode walks round-robin over
// the channels enabled in `en_mask`.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_flat    [N*W]   channel data, channel i at [i*W +: W]
//   mode       0 = manual, 1 = auto-scan
//   sel        [SEL_W] manual channel select
//   en_mask    [N]     per-channel enable (both modes)
//   out_data   [W]     registered selected data
//   out_chan   [SEL_W] channel index of out_data
//   out_valid  out_data/out_chan valid
//   out_ready  consumer accepts when out_valid && out_ready
//   sel_err    sticky manual-select error, cleared only by rst
// -----------------------------------------------------------------------------
module mux_scan_n
  import mux_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned W     = 8,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   in_flat,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N-1:0]     en_mask,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel_err
);

  logic [W-1:0]     r_data;
  logic [SEL_W-1:0] r_chan;
  logic             r_valid;
  logic             r_err;
  logic [SEL_W-1:0] r_ptr;

  logic [W-1:0]     w_nxt_data;
  logic [SEL_W-1:0] w_nxt_chan;
  logic             w_nxt_valid;
  logic             w_nxt_err;
  logic [SEL_W-1:0] w_nxt_ptr;

  logic             w_load;
  logic             w_sel_in_range;
  logic             w_sel_ok;
  logic             w_found;
  logic [SEL_W-1:0] w_found_idx;
  logic [SEL_W-1:0] w_ptr_after;
  logic [SEL_W-1:0] w_src;
  logic [W-1:0]     w_src_data;

  // A new beat may be captured when the output slot is empty or being taken.
  assign w_load = !r_valid || out_ready;

  // sel can exceed N-1 when N is not a power of two.
  assign w_sel_in_range = (32'(sel) < N);
  assign w_sel_ok       = w_sel_in_range && en_mask[sel];

  rr_find_next #(
    .N (N)
  ) u_find (
    .i_mask  (en_mask),
    .i_start (r_ptr),
    .o_found (w_found),
    .o_idx   (w_found_idx)
  );

  assign w_ptr_after = (32'(w_found_idx) == (N - 1)) ? {SEL_W{1'b0}}
                                                     : w_found_idx + SEL_W'(1);

  assign w_src      = (mode == MODE_SCAN) ? w_found_idx : sel;
  assign w_src_data = W'(chan_slice(CHAN_FLAT_MAX'(in_flat), 32'(w_src), W));

  // Next-state for the output beat, sticky error and scan pointer.
  always_comb begin
    w_nxt_data  = r_data;
    w_nxt_chan  = r_chan;
    w_nxt_valid = r_valid;
    w_nxt_err   = r_err;
    w_nxt_ptr   = r_ptr;
    if (w_load) begin
      case (mode)
        MODE_MANUAL: begin
          // ptr is left alone so scan resumes where it stopped.
          if (w_sel_ok) begin
            w_nxt_data  = w_src_data;
            w_nxt_chan  = sel;
            w_nxt_valid = 1'b1;
          end else begin
            w_nxt_valid = 1'b0;
            w_nxt_err   = 1'b1;
          end
        end
        MODE_SCAN: begin
          if (w_found) begin
            w_nxt_data  = w_src_data;
            w_nxt_chan  = w_found_idx;
            w_nxt_valid = 1'b1;
            w_nxt_ptr   = w_ptr_after;
          end else begin
            w_nxt_valid = 1'b0;
          end
        end
        default: begin
          w_nxt_valid = 1'b0;
        end
      endcase
    end else begin
      w_nxt_valid = r_valid;
    end
  end

  // Output and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= {W{1'b0}};
      r_chan  <= {SEL_W{1'b0}};
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ptr   <= {SEL_W{1'b0}};
    end else begin
      r_data  <= w_nxt_data;
      r_chan  <= w_nxt_chan;
      r_valid <= w_nxt_valid;
      r_err   <= w_nxt_err;
      r_ptr   <= w_nxt_ptr;
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;
  assign sel_err   = r_err;

endmodule

// File: tb/tb_mux_scan_n.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_n
// Self-checking bench for mux_scan_n: a table of directed cycles, a short N=3
// sequence on a second instance, and randomized cycles compared against a
// behavioural model.
// -----------------------------------------------------------------------------
module tb_mux_scan_n;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (N=4).
  logic           rst;
  logic [N*W-1:0] in_flat;
  logic           mode;
  logic [1:0]     sel;
  logic [N-1:0]   en_mask;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
  logic           out_valid;
  logic           sel_err;

  mux_scan_n #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_flat(in_flat), .mode(mode), .sel(sel),
    .en_mask(en_mask), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );

  // Second instance (N=3) for the out-of-range select case.
  logic        rst3;
  logic [23:0] in_flat3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [2:0]  en_mask3;
  logic        out_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        sel_err3;

  mux_scan_n #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst3), .in_flat(in_flat3), .mode(mode3), .sel(sel3),
    .en_mask(en_mask3), .out_data(out_data3), .out_chan(out_chan3),
    .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  logic [W-1:0] m_data;
  int           m_chan;
  logic         m_valid;
  logic         m_err;
  int           m_ptr;

  typedef struct {
    logic       rst;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] mask;
    logic       ready;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] ec;
    logic       ee;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic md, input logic [1:0] s,
                     input logic [3:0] mk, input logic rd, input logic ev,
                     input logic [7:0] ed, input logic [1:0] ec, input logic ee);
    vec_t v;
    v = '{r, md, s, mk, rd, ev, ed, ec, ee};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit hit;
    int c;
    if (rst) begin
      m_data = '0; m_chan = 0; m_valid = 1'b0; m_err = 1'b0; m_ptr = 0;
    end else if (!m_valid || out_ready) begin
      if (mode == 1'b0) begin
        if (int'(sel) < N && en_mask[sel]) begin
          m_data  = in_flat[int'(sel)*W +: W];
          m_chan  = int'(sel);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
          m_err   = 1'b1;
        end
      end else begin
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!hit && en_mask[c]) begin
            hit     = 1'b1;
            m_data  = in_flat[c*W +: W];
            m_chan  = c;
            m_ptr   = (c + 1) % N;
          end
        end
        m_valid = hit;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_flat = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; mode = 1'b0;
    sel = 2'd0; en_mask = 4'b1111; out_ready = 1'b1;
    rst3 = 1'b1; in_flat3 = {8'hC2, 8'hB1, 8'hA0}; mode3 = 1'b0;
    sel3 = 2'd0; en_mask3 = 3'b111; out_ready3 = 1'b1;

    //   rst  mode sel    mask     rdy   ev    data   ch     err
    add(1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0); // reset
    add(1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b0); // bit order
    add(1'b0, 1'b0, 2'd1, 4'b1111, 1'b1, 1'b1, 8'hB1, 2'd1, 1'b0);
    add(1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 1'b1, 8'hC2, 2'd2, 1'b0);
    add(1'b0, 1'b0, 2'd3, 4'b1111, 1'b1, 1'b1, 8'hD3, 2'd3, 1'b0);
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b0); // full scan
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hB1, 2'd1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hC2, 2'd2, 1'b0);
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hD3, 2'd3, 1'b0);
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b0); // wrap 3->0
    add(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 1'b1, 8'hB1, 2'd1, 1'b0); // masked scan
    add(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 1'b1, 8'hD3, 2'd3, 1'b0);
    add(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 1'b1, 8'hB1, 2'd1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 1'b1, 8'hD3, 2'd3, 1'b0);
    add(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0); // empty mask
    add(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b0); // ptr frozen at 0
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hB1, 2'd1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hC2, 2'd2, 1'b0);
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hD3, 2'd3, 1'b0);
    add(1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b1, 8'hD3, 2'd3, 1'b0); // stall, mask changes
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 1'b1, 8'hD3, 2'd3, 1'b0);
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 1'b1, 8'hD3, 2'd3, 1'b0);
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b0); // released
    add(1'b0, 1'b0, 2'd2, 4'b1011, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1); // disabled sel
    add(1'b0, 1'b0, 2'd0, 4'b1011, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b1); // err sticky
    add(1'b0, 1'b0, 2'd1, 4'b1011, 1'b1, 1'b1, 8'hB1, 2'd1, 1'b1);
    add(1'b0, 1'b0, 2'd3, 4'b1011, 1'b0, 1'b1, 8'hB1, 2'd1, 1'b1); // manual stall
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hB1, 2'd1, 1'b1); // scan resumes ptr=1
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hC2, 2'd2, 1'b1);
    add(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0); // mid-scan reset
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b0); // restarts at 0

    foreach (vecs[i]) begin
      rst = vecs[i].rst; mode = vecs[i].mode; sel = vecs[i].sel;
      en_mask = vecs[i].mask; out_ready = vecs[i].ready;
      step();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_err", i), 32'(sel_err), 32'(vecs[i].ee));
      if (vecs[i].ev || vecs[i].rst) begin
        check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].ed));
        check($sformatf("vec%0d_chan", i), 32'(out_chan), 32'(vecs[i].ec));
      end
    end

    // N=3 instance: select 3 is out of range.
    step();
    rst3 = 1'b0; sel3 = 2'd2;
    step();
    check("n3_sel2_valid", 32'(out_valid3), 32'd1);
    check("n3_sel2_data", 32'(out_data3), 32'hC2);
    check("n3_sel2_err", 32'(sel_err3), 32'd0);
    sel3 = 2'd3;
    step();
    check("n3_sel3_valid", 32'(out_valid3), 32'd0);
    check("n3_sel3_err", 32'(sel_err3), 32'd1);
    sel3 = 2'd0;
    step();
    check("n3_sel0_data", 32'(out_data3), 32'hA0);
    check("n3_sel0_chan", 32'(out_chan3), 32'd0);
    check("n3_sel0_err", 32'(sel_err3), 32'd1);

    // Randomized cycles against the model.
    for (int it = 0; it < 400; it++) begin
      rst       = ($urandom_range(0, 59) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      en_mask   = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_flat   = 32'($urandom);
      step();
      check("rnd_valid", 32'(out_valid), 32'(m_valid));
      check("rnd_err", 32'(sel_err), 32'(m_err));
      if (m_valid) begin
        check("rnd_data", 32'(out_data), 32'(m_data));
        check("rnd_chan", 32'(out_chan), 32'(m_chan));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
